// File: rtl/ccg_lut_engine.sv
// ccg_lut_engine: run-time loadable N_IN -> N_OUT truth table.
// A framed load fills the table, a 2-stage valid/ready pipeline evaluates it,
// and a MISR compacts every delivered result word into a signature.
module ccg_lut_engine #(
  parameter int unsigned      N_IN  = 5,
  parameter int unsigned      N_OUT = 8,
  parameter logic [N_OUT-1:0] POLY  = N_OUT'(8'h1D)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             cfg_last,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] f,
  output logic [N_OUT-1:0] sig,
  input  logic             sig_clr,
  output logic             loaded,
  output logic             err
);

  localparam int unsigned DEPTH = 1 << N_IN;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]       state;
  logic [N_IN-1:0]  row;
  logic [N_IN-1:0]  wr_row;
  logic             last_row;
  logic [N_OUT-1:0] tbl [DEPTH];

  logic             s1_valid;
  logic [N_IN-1:0]  s1_x;

  logic             adv;
  logic             cfg_fire;
  logic             in_fire;
  logic             out_fire;

  // Loading is only allowed with nothing in flight, so a table write can
  // never race a stage-2 read of the same table.
  assign cfg_ready = !s1_valid && !out_valid;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = (state == S_READY) && adv;

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // A beat outside LOAD always starts a fresh load at row 0.
  assign wr_row    = (state == S_LOAD) ? row : '0;
  assign last_row  = (wr_row == '1);

  // Load framing: row counter, state, loaded/err flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_EMPTY;
      row    <= '0;
      loaded <= 1'b0;
      err    <= 1'b0;
    end else if (cfg_fire) begin
      if (cfg_last) begin
        row <= '0;
        if (last_row) begin
          state  <= S_READY;
          loaded <= 1'b1;
          err    <= 1'b0;
        end else begin
          state  <= S_EMPTY;
          loaded <= 1'b0;
          err    <= 1'b1;
        end
      end else if (last_row) begin
        // overflow: final row written but the frame never closed
        row    <= '0;
        state  <= S_EMPTY;
        loaded <= 1'b0;
        err    <= 1'b1;
      end else begin
        row    <= wr_row + 1'b1;
        state  <= S_LOAD;
        loaded <= 1'b0;
        err    <= 1'b0;
      end
    end
  end

  // Truth-table storage, cleared by reset and written one row per cfg beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[N_IN'(i)] <= '0;
      end
    end else if (cfg_fire) begin
      tbl[wr_row] <= cfg_data;
    end
  end

  // Two-stage evaluation pipeline; both stages move on one shared enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      out_valid <= 1'b0;
      f         <= '0;
    end else if (adv) begin
      s1_valid  <= in_fire;
      if (in_fire) begin
        s1_x <= x;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        f <= tbl[s1_x];
      end
    end
  end

  // MISR signature over delivered words; clear wins over a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (sig_clr) begin
      sig <= '0;
    end else if (out_fire) begin
      sig <= ({sig[N_OUT-2:0], 1'b0} ^ (sig[N_OUT-1] ? POLY : '0)) ^ f;
    end
  end

endmodule

// File: tb/tb_ccg_lut_engine.sv
// Self-checking bench for ccg_lut_engine (N_IN=5, N_OUT=8, POLY=0x1D).
// Expected results are queued on each input handshake from a bench-side
// table copy and compared when the matching output handshake occurs.
module tb_ccg_lut_engine;

  localparam int unsigned N_IN  = 5;
  localparam int unsigned N_OUT = 8;
  localparam int unsigned DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [N_OUT-1:0] cfg_data = '0;
  logic             cfg_last = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N_IN-1:0]  x = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [N_OUT-1:0] f;
  logic [N_OUT-1:0] sig;
  logic             sig_clr = 1'b0;
  logic             loaded;
  logic             err;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  logic [N_OUT-1:0] model_tbl [DEPTH];
  logic [N_OUT-1:0] sb [$];
  logic [N_OUT-1:0] sig_model = '0;

  ccg_lut_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .POLY(8'h1D)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .f(f),
    .sig(sig), .sig_clr(sig_clr), .loaded(loaded), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
    logic [7:0] sh;
    sh = {s[6:0], 1'b0};
    if (s[7]) sh = sh ^ 8'h1D;
    return sh ^ d;
  endfunction

  // Scoreboard: inputs are stable from posedge+1 to the next posedge, so the
  // negedge sees exactly the handshakes that the coming edge will perform.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(model_tbl[x]);
      if (out_valid && out_ready) begin
        checks++;
        delivered++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_output got f=%02h want no output", f);
        end else begin
          logic [7:0] exp;
          exp = sb.pop_front();
          if (f !== exp) begin
            errors++;
            $display("FAIL sb_f got %02h want %02h", f, exp);
          end
        end
        if (!sig_clr) sig_model = misr_step(sig_model, f);
      end
      if (sig_clr) sig_model = '0;
    end
  end

  task automatic cfg_beat(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
    @(negedge clk);
    while (!cfg_ready && n < 50) begin n++; @(negedge clk); end
    if (!cfg_ready) begin
      checks++; errors++;
      $display("FAIL cfg_timeout got cfg_ready=0 want 1");
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic load_model();
    for (int i = 0; i < DEPTH; i++) cfg_beat(model_tbl[i], i == DEPTH - 1);
  endtask

  task automatic load_3i();
    for (int i = 0; i < DEPTH; i++) model_tbl[i] = 8'(3 * i);
    load_model();
  endtask

  task automatic send_vec(input logic [4:0] v);
    int n;
    n = 0;
    in_valid = 1'b1; x = v;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_timeout got in_ready=0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_timeout got out_valid=0 want 1");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset_now();
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_last = 1'b0; in_valid = 1'b0; sig_clr = 1'b0;
    sb.delete();
    sig_model = '0;
    for (int i = 0; i < DEPTH; i++) model_tbl[i] = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({cfg_ready, in_ready, out_valid, loaded, err} !== 5'b10000 || f !== 8'h00 || sig !== 8'h00) begin
      errors++;
      $display("FAIL %s got rdy/in/ov/ld/err=%b f=%02h sig=%02h want 10000 f=00 sig=00",
               tag, {cfg_ready, in_ready, out_valid, loaded, err}, f, sig);
    end
  endtask

  task automatic test_reset();
    apply_reset_now();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    release_reset();
    check_reset_outputs("after_release");
  endtask

  task automatic test_load_latency();
    out_ready = 1'b1;
    load_3i();
    checks++;
    if (loaded !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL load_flags got loaded=%b err=%b want 1 0", loaded, err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL load_in_ready got %b want 1", in_ready);
    end
    // vector presented after edge k, captured at k+1, result after k+2
    in_valid = 1'b1; x = 5'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_early got out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || f !== 8'h15) begin
      errors++; $display("FAIL lat_result got ov=%b f=%02h want 1 15", out_valid, f);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int base;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin in_valid = 1'b1; x = 5'(i); end
      else in_valid = 1'b0;
      checks++;
      if (i < 4 && in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      if (i >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || f !== 8'(3 * (i - 1))) begin
          errors++;
          $display("FAIL b2b_f[%0d] got ov=%b f=%02h want 1 %02h", i - 1, out_valid, f, 8'(3 * (i - 1)));
        end
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    // stall: fill both stages, hold out_ready low
    base = delivered;
    out_ready = 1'b0;
    in_valid = 1'b1; x = 5'd4;
    @(posedge clk); #1;
    x = 5'd5;
    @(posedge clk); #1;
    x = 5'd6;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || f !== 8'h0C) begin
        errors++;
        $display("FAIL stall[%0d] got in_ready=%b ov=%b f=%02h want 0 1 0c", c, in_ready, out_valid, f);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (delivered - base != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_count got delivered=%0d pending=%0d want 3 0", delivered - base, sb.size());
    end
  endtask

  task automatic test_short_load();
    for (int i = 0; i <= 10; i++) begin
      cfg_beat(8'(8'hA0 + i), i == 10);
      model_tbl[i] = 8'(8'hA0 + i);
      if (i == 0) begin
        checks++;
        if (loaded !== 1'b0 || in_ready !== 1'b0) begin
          errors++; $display("FAIL short_first got loaded=%b in_ready=%b want 0 0", loaded, in_ready);
        end
      end
    end
    checks++;
    if (err !== 1'b1 || loaded !== 1'b0 || in_ready !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL short_err got err=%b loaded=%b in_ready=%b cfg_ready=%b want 1 0 0 1",
               err, loaded, in_ready, cfg_ready);
    end
    load_3i();
    checks++;
    if (err !== 1'b0 || loaded !== 1'b1) begin
      errors++; $display("FAIL short_reload got err=%b loaded=%b want 0 1", err, loaded);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      cfg_beat(8'(8'h40 + i), 1'b0);
      model_tbl[i] = 8'(8'h40 + i);
      if (i == DEPTH - 2) begin
        checks++;
        if (err !== 1'b0) begin
          errors++; $display("FAIL ovf_early got err=%b want 0", err);
        end
      end
    end
    checks++;
    if (err !== 1'b1 || loaded !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL ovf_err got err=%b loaded=%b in_ready=%b want 1 0 0", err, loaded, in_ready);
    end
    cfg_beat(8'hEE, 1'b0);
    model_tbl[0] = 8'hEE;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL ovf_restart got err=%b want 0", err);
    end
    for (int i = 1; i < DEPTH; i++) cfg_beat(model_tbl[i], i == DEPTH - 1);
    checks++;
    if (loaded !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL ovf_reload got loaded=%b err=%b want 1 0", loaded, err);
    end
    out_ready = 1'b1;
    send_vec(5'd0);
    send_vec(5'd1);
    drain();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL ovf_pending got %0d want 0", sb.size());
    end
  endtask

  task automatic test_misr();
    for (int i = 0; i < DEPTH; i++) model_tbl[i] = 8'(i);
    model_tbl[0] = 8'h80; model_tbl[1] = 8'h01; model_tbl[2] = 8'h55;
    load_model();
    out_ready = 1'b0;
    sig_clr = 1'b1;
    @(posedge clk); #1;
    sig_clr = 1'b0;
    checks++;
    if (sig !== 8'h00) begin
      errors++; $display("FAIL misr_clr0 got %02h want 00", sig);
    end
    send_vec(5'd0); wait_out();
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (sig !== 8'h80) begin
      errors++; $display("FAIL misr_w1 got %02h want 80", sig);
    end
    send_vec(5'd1); wait_out();
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (sig !== 8'h1C || sig !== sig_model) begin
      errors++; $display("FAIL misr_w2 got %02h want 1c (model %02h)", sig, sig_model);
    end
    send_vec(5'd2); wait_out();
    out_ready = 1'b1; sig_clr = 1'b1;
    @(posedge clk); #1;
    sig_clr = 1'b0;
    checks++;
    if (sig !== 8'h00 || out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL misr_clr_hs got sig=%02h ov=%b pending=%0d want 00 0 0", sig, out_valid, sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 12; i++) cfg_beat(8'(i + 1), 1'b0);
    #2;
    apply_reset_now();
    #1;
    check_reset_outputs("rst_midload");
    release_reset();
    load_3i();
    out_ready = 1'b1;
    send_vec(5'd5);
    drain();
    checks++;
    if (sig !== 8'h0F) begin
      errors++; $display("FAIL rst_presig got %02h want 0f", sig);
    end
    out_ready = 1'b0;
    send_vec(5'd9);
    send_vec(5'd10);
    checks++;
    if (out_valid !== 1'b1 || f !== 8'h1B || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_inflight got ov=%b f=%02h in_ready=%b want 1 1b 0", out_valid, f, in_ready);
    end
    #2;
    apply_reset_now();
    #1;
    check_reset_outputs("rst_mideval");
    release_reset();
    load_3i();
    checks++;
    if (loaded !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL rst_reload got loaded=%b err=%b want 1 0", loaded, err);
    end
    out_ready = 1'b1;
    send_vec(5'd31);
    drain();
    checks++;
    if (sb.size() != 0 || sig !== sig_model) begin
      errors++; $display("FAIL rst_final got pending=%0d sig=%02h want 0 %02h", sb.size(), sig, sig_model);
    end
  endtask

  initial begin
    test_reset();
    test_load_latency();
    test_back_to_back();
    test_short_load();
    test_overflow();
    test_misr();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
